// File: rtl/ucode_memory_bank_pkg.sv
// Shared constants and types for the ucode memory bank.
//   DefaultDepth / DefaultDataWidth : default geometry of the store
//   ucode_mem_state_e               : bank FSM state (idle or clear sweep)
package pkg_ucode_mem;

   localparam int unsigned DefaultDepth     = 32;
   localparam int unsigned DefaultDataWidth = 32;

   typedef enum logic {
      StIdle  = 1'b0,
      StClear = 1'b1
   } ucode_mem_state_e;

endpackage

// File: rtl/ucode_memory_bank_if.sv
// Write (config) and read (sequencer) port bundle of the ucode memory bank.
//   wr_req_i/wr_addr_i/wr_data_i -> wr_gnt_o, wr_err_o         : write port
//   rd_req_i/rd_addr_i/rd_ready_i -> rd_gnt_o, rd_valid_o,
//                                    rd_data_o, rd_err_o        : read port
//   master : requester side, slave : memory side
interface ucode_memory_bank_if
   import pkg_ucode_mem::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = $clog2(DefaultDepth)
);

   logic                  wr_req_i;
   logic [ADDR_WIDTH-1:0] wr_addr_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic                  wr_gnt_o;
   logic                  wr_err_o;

   logic                  rd_req_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic                  rd_gnt_o;
   logic                  rd_valid_o;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic                  rd_err_o;
   logic                  rd_ready_i;

   modport master (
      output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, rd_ready_i,
      input  wr_gnt_o, wr_err_o, rd_gnt_o, rd_valid_o, rd_data_o, rd_err_o
   );

   modport slave (
      input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, rd_ready_i,
      output wr_gnt_o, wr_err_o, rd_gnt_o, rd_valid_o, rd_data_o, rd_err_o
   );

endinterface

// File: rtl/ucode_memory_bank_rd_stage.sv
// Registered read output with valid/ready hold.
//   clk_i, rst_ni : clock, async active-low reset
//   i_load        : read granted this cycle, capture i_data/i_err
//   i_ready       : consumer takes the current output
//   i_data, i_err : next read data and out-of-range flag
//   o_valid, o_data, o_err : registered read result
module ucode_mem_rd_stage
   import pkg_ucode_mem::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  i_load,
   input  logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_err,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_err
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_err;

   // Data and err only change on a new grant; a plain handshake just drops valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_err   <= i_err;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_err   = r_err;

endmodule

// File: rtl/ucode_memory_bank.sv
// Microcode store for the ucode sequencer: flop array with a config write port,
// a 1-cycle-latency sequencer read port, write lock and a one-row-per-cycle
// clear sweep.
//   clk_i, rst_ni : clock, async active-low reset (zeroes all rows)
//   clear_i       : pulse, start clear sweep (ignored while sweeping)
//   lock_i        : level, granted writes are discarded and flagged
//   io_bus        : write/read handshake bundle (slave side)
//   busy_o        : clear sweep in progress
module ucode_memory_bank
   import pkg_ucode_mem::*;
#(
   parameter int unsigned DEPTH      = DefaultDepth,
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                lock_i,
   ucode_memory_bank_if.slave  io_bus,
   output logic                busy_o
);

   ucode_mem_state_e      r_state, w_state_d;
   logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_d;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_wr_err;

   logic                  w_idle;
   logic                  w_wr_gnt, w_wr_ok, w_wr_in_range;
   logic                  w_rd_gnt, w_rd_in_range, w_rd_err_d;
   logic [DATA_WIDTH-1:0] w_rd_data_d;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         StIdle: begin
            if (clear_i) begin
               w_state_d = StClear;
               w_cnt_d   = '0;
            end
         end
         StClear: begin
            if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + ADDR_WIDTH'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_wr_err <= w_wr_gnt & ~w_wr_ok;
      end
   end

   assign w_idle        = (r_state == StIdle);
   assign w_wr_in_range = (32'(io_bus.wr_addr_i) < DEPTH);
   assign w_rd_in_range = (32'(io_bus.rd_addr_i) < DEPTH);
   assign w_wr_gnt      = io_bus.wr_req_i & w_idle;
   assign w_wr_ok       = w_wr_gnt & ~lock_i & w_wr_in_range;
   // A stalled output blocks new reads unless the consumer drains it this cycle.
   assign w_rd_gnt      = io_bus.rd_req_i & w_idle & (~io_bus.rd_valid_o | io_bus.rd_ready_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == StClear) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[io_bus.wr_addr_i] <= io_bus.wr_data_i;
      end
   end

   // Write-first: an accepted write to the row being read is forwarded.
   always_comb begin
      w_rd_data_d = '0;
      w_rd_err_d  = 1'b0;
      if (!w_rd_in_range) begin
         w_rd_err_d = 1'b1;
      end else if (w_wr_ok && (io_bus.wr_addr_i == io_bus.rd_addr_i)) begin
         w_rd_data_d = io_bus.wr_data_i;
      end else begin
         w_rd_data_d = r_mem[io_bus.rd_addr_i];
      end
   end

   ucode_mem_rd_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_load  (w_rd_gnt),
      .i_ready (io_bus.rd_ready_i),
      .i_data  (w_rd_data_d),
      .i_err   (w_rd_err_d),
      .o_valid (io_bus.rd_valid_o),
      .o_data  (io_bus.rd_data_o),
      .o_err   (io_bus.rd_err_o)
   );

   assign io_bus.wr_gnt_o = w_wr_gnt;
   assign io_bus.wr_err_o = r_wr_err;
   assign io_bus.rd_gnt_o = w_rd_gnt;
   assign busy_o          = (r_state == StClear);

endmodule

// File: tb/tb_ucode_memory_bank.sv
// Directed bench for ucode_memory_bank: a DEPTH=32 instance for the main flow
// and a DEPTH=20 instance for non-power-of-two depth and out-of-range access.
module tb_ucode_memory_bank;

   logic clk = 1'b0;
   logic rst_n;
   logic clear32, lock32, busy32;
   logic clear20, lock20, busy20;
   int   total = 0;
   int   bad   = 0;
   int   n;

   ucode_memory_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus32 ();
   ucode_memory_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus20 ();

   ucode_memory_bank #(.DEPTH(32), .DATA_WIDTH(32)) u_dut32 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (clear32),
      .lock_i  (lock32),
      .io_bus  (bus32),
      .busy_o  (busy32)
   );

   ucode_memory_bank #(.DEPTH(20), .DATA_WIDTH(32)) u_dut20 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (clear20),
      .lock_i  (lock20),
      .io_bus  (bus20),
      .busy_o  (busy20)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr32(input logic [4:0] a, input logic [31:0] d, input string tag);
      bus32.wr_req_i  = 1'b1;
      bus32.wr_addr_i = a;
      bus32.wr_data_i = d;
      #1;
      chk({tag, "_gnt"}, 32'(bus32.wr_gnt_o), 32'd1);
      tick();
      bus32.wr_req_i = 1'b0;
   endtask

   task automatic rd32(input logic [4:0] a, input logic [31:0] exp, input string tag);
      bus32.rd_req_i   = 1'b1;
      bus32.rd_addr_i  = a;
      bus32.rd_ready_i = 1'b1;
      #1;
      chk({tag, "_gnt"}, 32'(bus32.rd_gnt_o), 32'd1);
      tick();
      bus32.rd_req_i = 1'b0;
      chk({tag, "_valid"}, 32'(bus32.rd_valid_o), 32'd1);
      chk({tag, "_data"}, bus32.rd_data_o, exp);
      chk({tag, "_err"}, 32'(bus32.rd_err_o), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b1;
      clear32 = 1'b0; lock32 = 1'b0; clear20 = 1'b0; lock20 = 1'b0;
      bus32.wr_req_i = 1'b0; bus32.wr_addr_i = '0; bus32.wr_data_i = '0;
      bus32.rd_req_i = 1'b0; bus32.rd_addr_i = '0; bus32.rd_ready_i = 1'b0;
      bus20.wr_req_i = 1'b0; bus20.wr_addr_i = '0; bus20.wr_data_i = '0;
      bus20.rd_req_i = 1'b0; bus20.rd_addr_i = '0; bus20.rd_ready_i = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      // Reset state
      chk("rst_busy", 32'(busy32), 32'd0);
      chk("rst_wr_gnt", 32'(bus32.wr_gnt_o), 32'd0);
      chk("rst_wr_err", 32'(bus32.wr_err_o), 32'd0);
      chk("rst_rd_gnt", 32'(bus32.rd_gnt_o), 32'd0);
      chk("rst_rd_valid", 32'(bus32.rd_valid_o), 32'd0);
      chk("rst_rd_data", bus32.rd_data_o, 32'd0);
      chk("rst_rd_err", 32'(bus32.rd_err_o), 32'd0);
      chk("rst_busy20", 32'(busy20), 32'd0);
      @(posedge clk);
      tick();
      rst_n = 1'b1;
      tick();

      // Fill, then read back-to-back at one read per cycle
      for (int i = 0; i < 32; i++) wr32(5'(i), 32'hA000_0000 + i, "wr_fill");
      chk("wr_fill_no_err", 32'(bus32.wr_err_o), 32'd0);
      for (int i = 0; i < 32; i++) rd32(5'(i), 32'hA000_0000 + i, "rd_fill");
      tick();
      chk("drain_valid", 32'(bus32.rd_valid_o), 32'd0);
      chk("drain_data_hold", bus32.rd_data_o, 32'hA000_001F);

      // Locked write is granted, discarded and flagged for one cycle
      lock32 = 1'b1;
      wr32(5'd5, 32'hDEAD_BEEF, "wr_lock");
      lock32 = 1'b0;
      chk("wr_lock_err", 32'(bus32.wr_err_o), 32'd1);
      rd32(5'd5, 32'hA000_0005, "rd_lock");
      chk("wr_lock_err_pulse", 32'(bus32.wr_err_o), 32'd0);

      // Same-cycle write/read forwarding
      bus32.wr_req_i = 1'b1; bus32.wr_addr_i = 5'd7; bus32.wr_data_i = 32'h1234_5678;
      bus32.rd_req_i = 1'b1; bus32.rd_addr_i = 5'd7; bus32.rd_ready_i = 1'b1;
      #1;
      chk("fwd_wr_gnt", 32'(bus32.wr_gnt_o), 32'd1);
      chk("fwd_rd_gnt", 32'(bus32.rd_gnt_o), 32'd1);
      tick();
      bus32.wr_req_i = 1'b0; bus32.rd_req_i = 1'b0;
      chk("fwd_data", bus32.rd_data_o, 32'h1234_5678);
      rd32(5'd7, 32'h1234_5678, "rd_fwd_persist");

      // Backpressure: stall with req held, then one new grant on ready
      tick();
      bus32.rd_req_i = 1'b1; bus32.rd_addr_i = 5'd3; bus32.rd_ready_i = 1'b0;
      #1;
      chk("bp_first_gnt", 32'(bus32.rd_gnt_o), 32'd1);
      tick();
      chk("bp_first_data", bus32.rd_data_o, 32'hA000_0003);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_stall_gnt", 32'(bus32.rd_gnt_o), 32'd0);
         tick();
         chk("bp_stall_valid", 32'(bus32.rd_valid_o), 32'd1);
         chk("bp_stall_data", bus32.rd_data_o, 32'hA000_0003);
      end
      bus32.rd_addr_i = 5'd4; bus32.rd_ready_i = 1'b1;
      #1;
      chk("bp_release_gnt", 32'(bus32.rd_gnt_o), 32'd1);
      tick();
      bus32.rd_req_i = 1'b0;
      chk("bp_release_data", bus32.rd_data_o, 32'hA000_0004);
      tick();
      chk("bp_release_drain", 32'(bus32.rd_valid_o), 32'd0);

      // Clear sweep: same-cycle read still granted, grants blocked while busy
      clear32 = 1'b1;
      bus32.rd_req_i = 1'b1; bus32.rd_addr_i = 5'd1; bus32.rd_ready_i = 1'b1;
      #1;
      chk("clr_same_cycle_gnt", 32'(bus32.rd_gnt_o), 32'd1);
      tick();
      clear32 = 1'b0;
      chk("clr_pending_data", bus32.rd_data_o, 32'hA000_0001);
      chk("clr_pending_valid", 32'(bus32.rd_valid_o), 32'd1);
      lock32 = 1'b1;
      bus32.wr_req_i = 1'b1; bus32.wr_addr_i = 5'd0; bus32.wr_data_i = 32'hFFFF_FFFF;
      n = 0;
      while (busy32 && n < 40) begin
         clear32 = (n == 5);
         #1;
         chk("clr_rd_gnt", 32'(bus32.rd_gnt_o), 32'd0);
         chk("clr_wr_gnt", 32'(bus32.wr_gnt_o), 32'd0);
         tick();
         n++;
      end
      clear32 = 1'b0; lock32 = 1'b0;
      bus32.wr_req_i = 1'b0; bus32.rd_req_i = 1'b0;
      chk("clr_busy_cycles", 32'(n), 32'd32);
      for (int i = 0; i < 32; i++) rd32(5'(i), 32'd0, "rd_cleared");

      // DEPTH=20: out-of-range write/read and a 20-cycle sweep
      bus20.wr_req_i = 1'b1; bus20.wr_addr_i = 5'd19; bus20.wr_data_i = 32'h77;
      #1;
      chk("d20_wr_gnt", 32'(bus20.wr_gnt_o), 32'd1);
      tick();
      chk("d20_wr_ok_err", 32'(bus20.wr_err_o), 32'd0);
      bus20.wr_addr_i = 5'd25; bus20.wr_data_i = 32'h99;
      tick();
      bus20.wr_req_i = 1'b0;
      chk("d20_wr_oor_err", 32'(bus20.wr_err_o), 32'd1);
      bus20.rd_req_i = 1'b1; bus20.rd_addr_i = 5'd19; bus20.rd_ready_i = 1'b1;
      #1;
      chk("d20_rd_gnt", 32'(bus20.rd_gnt_o), 32'd1);
      tick();
      chk("d20_rd19_data", bus20.rd_data_o, 32'h77);
      chk("d20_rd19_err", 32'(bus20.rd_err_o), 32'd0);
      bus20.rd_addr_i = 5'd25;
      tick();
      bus20.rd_req_i = 1'b0;
      chk("d20_rd25_valid", 32'(bus20.rd_valid_o), 32'd1);
      chk("d20_rd25_data", bus20.rd_data_o, 32'd0);
      chk("d20_rd25_err", 32'(bus20.rd_err_o), 32'd1);
      clear20 = 1'b1;
      tick();
      clear20 = 1'b0;
      n = 0;
      while (busy20 && n < 40) begin
         tick();
         n++;
      end
      chk("d20_busy_cycles", 32'(n), 32'd20);
      bus20.rd_req_i = 1'b1; bus20.rd_addr_i = 5'd19;
      tick();
      bus20.rd_req_i = 1'b0;
      chk("d20_cleared_data", bus20.rd_data_o, 32'd0);
      chk("d20_cleared_err", 32'(bus20.rd_err_o), 32'd0);

      // Async reset at cycle 10 of a sweep
      wr32(5'd2, 32'h0000_BBBB, "wr_pre_rst");
      wr32(5'd30, 32'h0000_CCCC, "wr_pre_rst");
      clear32 = 1'b1;
      bus32.rd_req_i = 1'b1; bus32.rd_addr_i = 5'd30; bus32.rd_ready_i = 1'b1;
      tick();
      clear32 = 1'b0; bus32.rd_req_i = 1'b0; bus32.rd_ready_i = 1'b0;
      repeat (10) tick();
      chk("mid_busy", 32'(busy32), 32'd1);
      chk("mid_hold_valid", 32'(bus32.rd_valid_o), 32'd1);
      chk("mid_hold_data", bus32.rd_data_o, 32'h0000_CCCC);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy32), 32'd0);
      chk("arst_valid", 32'(bus32.rd_valid_o), 32'd0);
      chk("arst_data", bus32.rd_data_o, 32'd0);
      chk("arst_wr_err", 32'(bus32.wr_err_o), 32'd0);
      tick();
      rst_n = 1'b1;
      rd32(5'd30, 32'd0, "rd_after_rst30");
      rd32(5'd2, 32'd0, "rd_after_rst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
